// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared widths, latency limit and MAC mode encoding for the systolic array
package sys_arr_pkg;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int MAC_LAT_MAX = 8;
  typedef enum logic [1:0] {MAC_UNSIGNED, MAC_SIGNED, MAC_MUL, MAC_SAT} mac_mode_t;
endpackage

// File: rtl/sysarr_mac_mulpipe.sv
// sysarr_mac_mulpipe: DW x DW multiplier feeding a MUL_LAT-deep valid/product/mode pipe
//   start,a,b,mode_in -> launch; vld,prod,mode_out -> final stage; busy -> any stage valid
module sysarr_mac_mulpipe import sys_arr_pkg::*; #(
  parameter int DW = sys_arr_pkg::DW,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  mac_mode_t       mode_in,
  output logic            vld,
  output logic [2*DW-1:0] prod,
  output mac_mode_t       mode_out,
  output logic            busy
);
  logic [MUL_LAT-1:0] v;
  logic [2*DW-1:0] p [MUL_LAT];
  mac_mode_t m [MUL_LAT];
  logic [2*DW-1:0] ax, bx, pc;
  // one multiplier serves both signednesses: extend operands to 2*DW, keep the low half
  always_comb begin
    ax = mode_in == MAC_UNSIGNED ? {{DW{1'b0}}, a} : {{DW{a[DW-1]}}, a};
    bx = mode_in == MAC_UNSIGNED ? {{DW{1'b0}}, b} : {{DW{b[DW-1]}}, b};
    pc = ax * bx;
  end
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        p[i] <= '0;
        m[i] <= MAC_UNSIGNED;
      end
    end else begin
      v[0] <= start;
      p[0] <= pc;
      m[0] <= mode_in;
      for (int i = 1; i < MUL_LAT; i++) begin
        v[i] <= v[i-1];
        p[i] <= p[i-1];
        m[i] <= m[i-1];
      end
    end
  assign vld = v[MUL_LAT-1];
  assign prod = p[MUL_LAT-1];
  assign mode_out = m[MUL_LAT-1];
  assign busy = |v;
endmodule

// File: rtl/sysarr_mac_pipe.sv
// sysarr_mac_pipe: pipelined systolic-array PE with x/weight regs and mode-selected MAC completion
//   MAC_shift/in_value -> x reg -> in_pass; weight_load/weight_in -> weight reg
//   start/mode launch an op; in_accumulate joins at completion -> out_accumulate, value_ready, ovf; busy
module sysarr_mac_pipe import sys_arr_pkg::*; #(
  parameter int DW = sys_arr_pkg::DW,
  parameter int AW = sys_arr_pkg::AW,
  parameter int MUL_LAT = 3
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          MAC_shift,
  input  logic [DW-1:0] in_value,
  output logic [DW-1:0] in_pass,
  input  logic          weight_load,
  input  logic [DW-1:0] weight_in,
  input  logic          start,
  input  mac_mode_t     mode,
  input  logic [AW-1:0] in_accumulate,
  output logic [AW-1:0] out_accumulate,
  output logic          value_ready,
  output logic          ovf,
  output logic          busy
);
  if (AW < 2*DW) begin : g_aw_chk
    $error("AW must be at least 2*DW");
  end
  if (MUL_LAT < 1 || MUL_LAT > MAC_LAT_MAX) begin : g_lat_chk
    $error("MUL_LAT out of range");
  end
  logic [DW-1:0] x, w;
  logic vld;
  logic [2*DW-1:0] prod;
  mac_mode_t md;
  logic [AW-1:0] ps, pu, pe, res;
  logic [AW:0] su;
  logic sov, flag;
  always_ff @(posedge clk)
    if (RST) begin
      x <= '0;
      w <= '0;
    end else begin
      if (MAC_shift) x <= in_value;
      if (weight_load) w <= weight_in;
    end
  sysarr_mac_mulpipe #(.DW(DW), .MUL_LAT(MUL_LAT)) u_mul (
    .clk(clk), .rst(RST), .start(start), .a(x), .b(w), .mode_in(mode),
    .vld(vld), .prod(prod), .mode_out(md), .busy(busy)
  );
  // the low AW bits of the sum are shared by signed and unsigned modes; only the flag differs
  always_comb begin
    ps = AW'($signed(prod));
    pu = AW'(prod);
    pe = md == MAC_UNSIGNED ? pu : ps;
    su = {1'b0, pe} + {1'b0, in_accumulate};
    sov = pe[AW-1] == in_accumulate[AW-1] && su[AW-1] != pe[AW-1];
    res = md == MAC_MUL ? pe
        : md == MAC_SAT && sov ? (pe[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}})
        : su[AW-1:0];
    flag = md == MAC_UNSIGNED ? su[AW] : md == MAC_MUL ? 1'b0 : sov;
    out_accumulate = vld ? res : '0;
    ovf = vld & flag;
  end
  assign value_ready = vld;
  assign in_pass = x;
endmodule

// File: tb/tb_sysarr_mac_pipe.sv
// tb_sysarr_mac_pipe: scoreboard bench with an arithmetic reference model for sysarr_mac_pipe
module tb_sysarr_mac_pipe;
  import sys_arr_pkg::*;
  localparam int LAT = 3;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  typedef struct {
    logic [15:0] x;
    logic [15:0] w;
    logic [1:0] md;
    int c;
  } op_t;
  logic clk = 0, RST = 1, MAC_shift = 0, weight_load = 0, start = 0;
  logic [15:0] in_value = 0, weight_in = 0, in_pass;
  mac_mode_t mode = MAC_UNSIGNED;
  logic [31:0] in_accumulate = 0, out_accumulate;
  logic value_ready, ovf, busy;
  int checks = 0, errors = 0, cyc = 0, t0;
  logic [15:0] x_m = 0, w_m = 0;
  op_t sb[$];
  sysarr_mac_pipe #(.DW(16), .AW(32), .MUL_LAT(LAT)) dut (
    .clk(clk), .RST(RST), .MAC_shift(MAC_shift), .in_value(in_value), .in_pass(in_pass),
    .weight_load(weight_load), .weight_in(weight_in), .start(start), .mode(mode),
    .in_accumulate(in_accumulate), .out_accumulate(out_accumulate),
    .value_ready(value_ready), .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic void model(input op_t e, input logic [31:0] acc, output logic [31:0] o, output logic v);
    longint p, s;
    if (e.md == 2'd0) begin
      p = longint'({48'b0, e.x}) * longint'({48'b0, e.w});
      s = p + longint'({32'b0, acc});
      o = s[31:0];
      v = s > 64'sh0000_0000_FFFF_FFFF;
    end else begin
      p = longint'($signed(e.x)) * longint'($signed(e.w));
      s = p + longint'($signed(acc));
      v = e.md != 2'd2 && (s > MAXV || s < MINV);
      o = e.md == 2'd2 ? p[31:0] : e.md == 2'd1 ? s[31:0]
        : s > MAXV ? 32'h7FFF_FFFF : s < MINV ? 32'h8000_0000 : s[31:0];
    end
  endfunction
  task automatic step(input bit st, input logic [1:0] md, input bit sh, input logic [15:0] iv,
                      input bit wl, input logic [15:0] wi, input logic [31:0] acc);
    start = st;
    mode = mac_mode_t'(md);
    MAC_shift = sh;
    in_value = iv;
    weight_load = wl;
    weight_in = wi;
    in_accumulate = acc;
    if (RST) begin
      x_m = 0;
      w_m = 0;
    end else begin
      if (st) sb.push_back('{x: x_m, w: w_m, md: md, c: cyc});
      if (sh) x_m = iv;
      if (wl) w_m = wi;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input logic [31:0] acc);
    step(0, 0, 0, 0, 0, 0, acc);
  endtask
  function automatic logic [15:0] pick();
    case ($urandom % 4)
      0: return 16'h8000;
      1: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction
  always @(negedge clk) begin
    op_t e;
    logic [31:0] eo;
    logic ev;
    if (value_ready) begin
      if (sb.size() == 0) chk("unexpected_ready", value_ready, 0);
      else begin
        e = sb.pop_front();
        model(e, in_accumulate, eo, ev);
        chk("latency", cyc, e.c + LAT);
        chk("out", out_accumulate, eo);
        chk("ovf", ovf, ev);
      end
    end else begin
      chk("idle_out", out_accumulate, 0);
      chk("idle_ovf", ovf, 0);
      if (sb.size() > 0 && sb[0].c + LAT <= cyc) begin
        void'(sb.pop_front());
        chk("missing_ready", value_ready, 1);
      end
    end
  end
  initial begin
    RST = 1;
    step(1, 0, 1, 16'h1234, 1, 16'h5678, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    RST = 0;
    chk("rst_in_pass", in_pass, 0);
    chk("rst_ready", value_ready, 0);
    chk("rst_out", out_accumulate, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    repeat (10) idle(0);
    step(0, 0, 1, 3, 1, 5, 7);
    step(1, 0, 0, 0, 0, 0, 7);
    repeat (LAT + 1) idle(7);
    step(0, 0, 1, 1, 1, 2, 0);
    t0 = cyc;
    for (int k = 1; k <= 4; k++) step(1, 1, 1, 16'(k + 1), 0, 0, 0);
    while (cyc < t0 + 3 + LAT) idle(0);
    chk("busy_last", busy, 1);
    idle(0);
    chk("busy_fall", busy, 0);
    step(0, 0, 1, 16'h8000, 1, 16'h8000, 0);
    step(1, 1, 0, 0, 0, 0, 32'h7FFF_FFFF);
    step(1, 3, 0, 0, 0, 0, 32'h7FFF_FFFF);
    repeat (LAT + 1) idle(32'h7FFF_FFFF);
    step(0, 0, 1, 16'hFFFE, 1, 3, 0);
    step(1, 2, 0, 0, 0, 0, 32'h1234_5678);
    repeat (LAT + 1) idle(32'h1234_5678);
    step(0, 0, 1, 4, 1, 2, 0);
    step(1, 1, 1, 9, 1, 7, 0);
    chk("in_pass_shift", in_pass, 9);
    step(1, 1, 0, 0, 0, 0, 0);
    repeat (LAT + 1) idle(0);
    step(1, 0, 0, 0, 0, 0, 0);
    RST = 1;
    sb.delete();
    idle(0);
    RST = 0;
    chk("busy_after_rst", busy, 0);
    repeat (LAT + 2) idle(0);
    step(0, 0, 1, 16'h00FF, 1, 16'h0101, 0);
    repeat (400) begin
      logic [31:0] acc;
      case ($urandom % 4)
        0: acc = 32'h7FFF_FFFF;
        1: acc = 32'h8000_0000;
        default: acc = $urandom;
      endcase
      step($urandom % 3 != 0, 2'($urandom), $urandom % 2 == 0, pick(), $urandom % 3 == 0, pick(), acc);
    end
    repeat (LAT + 2) idle(0);
    chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
